// File: rtl/tx_fifo_pkg.sv
// rtl/tx_fifo_pkg.sv - sizing defaults and width helpers shared by the transmit FIFO blocks
package tx_fifo_pkg;

  localparam int TX_DATA_W_DEF = 8;
  localparam int TX_DEPTH_DEF  = 1024;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy runs 0..DEPTH inclusive, so one bit wider than the pointers.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tx_fifo_if.sv
// rtl/tx_fifo_if.sv - transmit FIFO handshake/status bundle with producer/consumer views
interface tx_fifo_if
  import tx_fifo_pkg::*;
#(
  parameter int DATA_W = TX_DATA_W_DEF,
  parameter int DEPTH  = TX_DEPTH_DEF
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] shiftIn;
  logic              push;
  logic              pop;
  logic              clr_err;
  logic [DATA_W-1:0] shiftOut;
  logic              out_valid;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;
  logic              almost_full;
  logic              almost_empty;

  modport master (
    output shiftIn, push, pop, clr_err,
    input  shiftOut, out_valid, full, empty, count,
           overflow, underflow, almost_full, almost_empty
  );

  modport slave (
    input  shiftIn, push, pop, clr_err,
    output shiftOut, out_valid, full, empty, count,
           overflow, underflow, almost_full, almost_empty
  );

endinterface

// File: rtl/tx_fifo_ram.sv
// rtl/tx_fifo_ram.sv - simple dual-port storage, one write port and one registered read port
module tx_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read-before-write: a same-address write+read returns the old word (full FIFO push+pop).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - transmit FIFO: pointers, occupancy, status and sticky error flags
// Optional almost_full/almost_empty thresholds enabled by TX_FIFO_THRESH_EN.
module tx_fifo
  import tx_fifo_pkg::*;
#(
  parameter int DATA_W   = TX_DATA_W_DEF,
  parameter int DEPTH    = TX_DEPTH_DEF
`ifdef TX_FIFO_THRESH_EN
  ,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
`endif
) (
  input logic       clk,
  input logic       rst,
  tx_fifo_if.slave  bus
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q, out_valid_q, overflow_q, underflow_q;
  logic              push_ok, pop_ok;

  // A push into a full FIFO is still taken when the same-cycle pop frees a slot.
  assign pop_ok  = bus.pop && !empty_q;
  assign push_ok = bus.push && (!full_q || bus.pop);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q     <= count_d;
      full_q      <= (count_d == CNT_W'(DEPTH));
      empty_q     <= (count_d == '0);
      out_valid_q <= pop_ok;
      overflow_q  <= (overflow_q && !bus.clr_err) || (bus.push && full_q && !bus.pop);
      underflow_q <= (underflow_q && !bus.clr_err) || (bus.pop && empty_q);
    end
  end

  tx_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (push_ok && !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.shiftIn),
    .re_i    (pop_ok && !rst),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.shiftOut)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

`ifdef TX_FIFO_THRESH_EN
  logic almost_full_q, almost_empty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_d >= CNT_W'(AF_LEVEL));
      almost_empty_q <= (count_d <= CNT_W'(AE_LEVEL));
    end
  end

  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
`else
  assign bus.almost_full  = 1'b0;
  assign bus.almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_tx_fifo.sv
// tb/tb_tx_fifo.sv - self-checking bench for tx_fifo against a queue-based reference model
module tb_tx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF_LVL = 6;
  localparam int AE_LVL = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  tx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  tx_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH)
`ifdef TX_FIFO_THRESH_EN
    ,
    .AF_LEVEL (AF_LVL),
    .AE_LEVEL (AE_LVL)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: a plain queue of stored words plus the last popped word and flags.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_out;
  logic              m_valid, m_ovf, m_unf;

  function automatic logic m_af();
`ifdef TX_FIFO_THRESH_EN
    return q.size() >= AF_LVL;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_ae();
`ifdef TX_FIFO_THRESH_EN
    return q.size() <= AE_LVL;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input logic ps, input logic pp, input logic [DATA_W-1:0] d, input logic ce);
    logic was_full, was_empty;
    bus.push = ps; bus.pop = pp; bus.shiftIn = d; bus.clr_err = ce;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    m_valid = 1'b0;
    if (pp && !was_empty) begin
      m_out = q.pop_front();
      m_valid = 1'b1;
    end
    if (ps && (!was_full || pp)) q.push_back(d);
    m_ovf = (ps && was_full && !pp) ? 1'b1 : (ce ? 1'b0 : m_ovf);
    m_unf = (pp && was_empty)       ? 1'b1 : (ce ? 1'b0 : m_unf);
    #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; bus.push = 1'b1; bus.pop = 1'b1; bus.shiftIn = 8'hEE; bus.clr_err = 1'b0;
    @(posedge clk);
    q.delete(); m_out = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    rst = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total += 7;
    if (bus.count !== 0)        begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    if (bus.empty !== 1'b1)     begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    if (bus.full !== 1'b0)      begin bad++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    if (bus.shiftOut !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.shiftOut); end
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    if ({bus.overflow, bus.underflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {bus.overflow, bus.underflow}); end
    if ({bus.almost_full, bus.almost_empty} !== {m_af(), m_ae()})
      begin bad++; $display("FAIL reset_almost got=%b exp=%b", {bus.almost_full, bus.almost_empty}, {m_af(), m_ae()}); end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, 8'h00, 1'b0);
    total += 4;
    if (bus.underflow !== 1'b1) begin bad++; $display("FAIL unf_set got=%b exp=1", bus.underflow); end
    if (bus.empty !== 1'b1)     begin bad++; $display("FAIL unf_empty got=%b exp=1", bus.empty); end
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL unf_valid got=%b exp=0", bus.out_valid); end
    if (bus.count !== 0)        begin bad++; $display("FAIL unf_count got=%0d exp=0", bus.count); end
    step(1'b0, 1'b1, 8'h00, 1'b1);
    total++;
    if (bus.underflow !== 1'b1) begin bad++; $display("FAIL unf_clr_race got=%b exp=1", bus.underflow); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    total++;
    if (bus.underflow !== 1'b0) begin bad++; $display("FAIL unf_clr got=%b exp=0", bus.underflow); end
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, vals[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      total++;
      if (bus.shiftOut !== vals[i] || bus.out_valid !== 1'b1)
        begin bad++; $display("FAIL basic_pop%0d got=%h/%b exp=%h/1", i, bus.shiftOut, bus.out_valid, vals[i]); end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    total++;
    if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0 || bus.shiftOut !== 8'h33)
      begin bad++; $display("FAIL basic_after got=%b/%b/%h exp=1/0/33", bus.empty, bus.out_valid, bus.shiftOut); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DATA_W'(i), 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    total++;
    if (bus.full !== 1'b1 || bus.overflow !== 1'b1 || bus.count !== 4'd8)
      begin bad++; $display("FAIL ovf_state got=%b/%b/%0d exp=1/1/8", bus.full, bus.overflow, bus.count); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      total++;
      if (bus.shiftOut !== DATA_W'(i)) begin bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, bus.shiftOut, i); end
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    total++;
    if (bus.empty !== 1'b1 || bus.overflow !== 1'b0)
      begin bad++; $display("FAIL ovf_end got=%b/%b exp=1/0", bus.empty, bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DATA_W'(i), 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    total++;
    if (bus.shiftOut !== 8'h00 || bus.count !== 4'd8 || bus.overflow !== 1'b0 || bus.full !== 1'b1)
      begin bad++; $display("FAIL fpp_state got=%h/%0d/%b/%b exp=00/8/0/1", bus.shiftOut, bus.count, bus.overflow, bus.full); end
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      total++;
      if (bus.shiftOut !== ((i == DEPTH) ? 8'h55 : DATA_W'(i)))
        begin bad++; $display("FAIL fpp_drain%0d got=%h exp=%h", i, bus.shiftOut, (i == DEPTH) ? 8'h55 : DATA_W'(i)); end
    end
  endtask

  task automatic test_empty_push_pop();
    step(1'b1, 1'b1, 8'h66, 1'b0);
    total++;
    if (bus.underflow !== 1'b1 || bus.count !== 4'd1 || bus.out_valid !== 1'b0 || bus.empty !== 1'b0)
      begin bad++; $display("FAIL epp_state got=%b/%0d/%b/%b exp=1/1/0/0", bus.underflow, bus.count, bus.out_valid, bus.empty); end
    step(1'b0, 1'b1, 8'h00, 1'b1);
    total++;
    if (bus.shiftOut !== 8'h66 || bus.out_valid !== 1'b1 || bus.underflow !== 1'b0)
      begin bad++; $display("FAIL epp_read got=%h/%b/%b exp=66/1/0", bus.shiftOut, bus.out_valid, bus.underflow); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DATA_W'($urandom), 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step(1'b1, 1'b1, DATA_W'($urandom), 1'b0);
      total++;
      if (bus.shiftOut !== m_out || bus.out_valid !== 1'b1 || bus.count !== 4'd4)
        begin bad++; $display("FAIL stream%0d got=%h/%b/%0d exp=%h/1/4", i, bus.shiftOut, bus.out_valid, bus.count, m_out); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), DATA_W'($urandom), ($urandom_range(0, 99) < 5));
      total++;
      if (bus.count !== q.size() || bus.full !== (q.size() == DEPTH) || bus.empty !== (q.size() == 0) ||
          bus.shiftOut !== m_out || bus.out_valid !== m_valid || bus.overflow !== m_ovf ||
          bus.underflow !== m_unf || bus.almost_full !== m_af() || bus.almost_empty !== m_ae())
        begin
          bad++;
          $display("FAIL rnd%0d got cnt=%0d f=%b e=%b d=%h v=%b o=%b u=%b af=%b ae=%b exp cnt=%0d d=%h v=%b o=%b u=%b af=%b ae=%b",
                   i, bus.count, bus.full, bus.empty, bus.shiftOut, bus.out_valid, bus.overflow, bus.underflow,
                   bus.almost_full, bus.almost_empty, q.size(), m_out, m_valid, m_ovf, m_unf, m_af(), m_ae());
        end
    end
  endtask

`ifdef TX_FIFO_THRESH_EN
  task automatic test_thresh();
    apply_reset();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0, DATA_W'(i), 1'b0);
      total++;
      if (bus.almost_full !== (i >= 6) || bus.almost_empty !== (i <= 2))
        begin bad++; $display("FAIL thr_fill%0d got=%b/%b exp=%b/%b", i, bus.almost_full, bus.almost_empty, i >= 6, i <= 2); end
    end
    for (int i = 5; i >= 2; i--) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      total++;
      if (bus.almost_full !== 1'b0 || bus.almost_empty !== (i <= 2))
        begin bad++; $display("FAIL thr_drain%0d got=%b/%b exp=0/%b", i, bus.almost_full, bus.almost_empty, i <= 2); end
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h77, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    apply_reset();
    total++;
    if (bus.count !== 0 || bus.empty !== 1'b1 || bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0 || bus.shiftOut !== 8'h00)
      begin bad++; $display("FAIL thr_rst got=%0d/%b/%b/%b/%h exp=0/1/1/0/00", bus.count, bus.empty, bus.almost_empty, bus.almost_full, bus.shiftOut); end
  endtask
`endif

  initial begin
    rst = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0; bus.shiftIn = '0;
    m_out = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_underflow();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_stream();
    test_random();
`ifdef TX_FIFO_THRESH_EN
    test_thresh();
`endif
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_fifo.md
# tx_fifo

Parametrised synchronous FIFO that buffers transmit data words between the VLC framing logic and the LED modulator/serialiser. Supersedes the fixed 1024-entry output buffer: configurable width and depth, full/empty status, occupancy count, registered read data with a valid strobe, and sticky overflow/underflow error flags. Single clock domain. Storage is not reset.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 1024, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-4, almost-full threshold: occupancy ≥ AF_LEVEL (only with the configuration macro)
- AE_LEVEL, 4, almost-empty threshold: occupancy ≤ AE_LEVEL (only with the configuration macro)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- shiftIn  in  DATA_W  write data
- push  in  1  write request
- pop  in  1  read request
- clr_err  in  1  clears overflow/underflow flags
- shiftOut  out  DATA_W  registered read data
- out_valid  out  1  shiftOut updated this cycle by an accepted pop
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: push rejected while full
- underflow  out  1  sticky: pop rejected while empty
- almost_full  out  1  see Configuration
- almost_empty  out  1  see Configuration

## Operation
- Pointers wr_ptr, rd_ptr: $clog2(DEPTH) bits, wrap DEPTH-1 → 0 by natural overflow.
- Accepted push: push && (!full || pop). Writes shiftIn to mem[wr_ptr], wr_ptr+1.
- Accepted pop: pop && !empty. shiftOut ← mem[rd_ptr], rd_ptr+1, out_valid=1 next cycle.
- count: +1 on push-only accept, −1 on pop-only accept, unchanged when both or neither.
- Full + push + pop: both accepted, count stays DEPTH, no overflow.
- Empty + push + pop: push accepted, pop rejected, underflow set, count → 1; data readable from next cycle.
- Full + push without pop: write dropped, memory/pointers unchanged, overflow ← 1.
- Empty + pop without push: nothing changes except underflow ← 1, out_valid 0.
- shiftOut holds last popped value when no pop accepted.
- Flags sticky until clr_err or rst; a new error event in the same cycle as clr_err wins (flag stays 1).
- full/empty derived from registered count; no combinational path from push/pop to any output.

## Timing
- Reset (rst high at clk edge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, shiftOut=0, out_valid=0, overflow=underflow=0, almost_empty=1, almost_full=0. Overrides push/pop in the same cycle. Reset mid-operation discards all contents.
- Write-to-read latency: word pushed at edge N poppable at edge N+1; appears on shiftOut after edge N+1 pop.
- Read latency: 1 cycle from accepted pop to shiftOut/out_valid.
- Status (count, full, empty, almost_*) valid the cycle after the causing edge.

## Configuration
- TX_FIFO_THRESH_EN defined: almost_full = (count ≥ AF_LEVEL), almost_empty = (count ≤ AE_LEVEL), registered with count.
- Not defined: almost_full and almost_empty tied to 0; AF_LEVEL/AE_LEVEL ignored; no threshold comparators synthesised.

## Structure
- Package tx_fifo_pkg: default DATA_W/DEPTH constants, ADDR_W/CNT_W derivation helpers, shared by transmitter blocks.
- Sub-module tx_fifo_ram: simple dual-port memory, one write port, one registered read port (infers block RAM); tx_fifo holds pointers, count, flags.

## Test plan
- Reset then pop with no push → underflow=1, empty=1, out_valid=0, count=0; clr_err → underflow=0.
- Push 0x11,0x22,0x33; pop ×3 → shiftOut 0x11,0x22,0x33 on consecutive cycles with out_valid=1, empty=1 after.
- Fill DEPTH=8 with 0..7, push 0xAA → full=1, overflow=1, count=8; drain reads 0..7, 0xAA absent.
- Full, push 0x55 + pop same cycle → shiftOut=oldest, count=8, overflow=0; 0x55 read last.
- Push/pop streaming 3×DEPTH words → pointers wrap, data order preserved, count constant.
- TX_FIFO_THRESH_EN, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2: push 6 → almost_full=1; pop to 2 → almost_empty=1; rst mid-fill → all outputs at reset values.
